seg_scan_ctrl: RTL and testbench

Autonomous scan controller for the 6-digit 7-segment display port. It holds six digit registers and one control register written from the bus-side write path. It time-multiplexes SEG_COM/SEG_DATA with a guard-blank interval and programmable brightness, so the CPU only writes digit values instead of refreshing the display in software. It sits between the address-decoder write path (already synchronised to CLK) and the SEG_DATA/SEG_COM pins.

---
 rtl/seg_scan_ctrl.sv | 166 ++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Six-digit 7-segment scan controller: digit/control registers, a prescaled
// tick counter and a per-slot guard/on/off phase with brightness control.
module seg_scan_ctrl #(
    parameter int DIV = 500
) (
    input  logic       CLK,
    input  logic       nRESET,
    input  logic       WR_EN,
    input  logic [2:0] WR_ADDR,
    input  logic [7:0] WR_DATA,
    output logic [7:0] SEG_DATA,
    output logic [5:0] SEG_COM,
    output logic [2:0] SCAN_IDX,
    output logic       FRAME_DONE
);

    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

    typedef enum logic [1:0] {
        IDLE,
        GUARD,
        ON,
        OFF
    } phase_e;

    phase_e        state_q, state_d;
    logic [5:0]    ctrl_q, ctrl_d;
    logic [7:0]    digit_q [6];
    logic [7:0]    digit_d [6];
    logic [PW-1:0] pres_q, pres_d;
    logic [3:0]    t_q, t_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shadow_q, shadow_d;
    logic [3:0]    bright_q, bright_d;
    logic          hex_q, hex_d;
    logic [7:0]    seg_data_q, seg_data_d;
    logic [5:0]    seg_com_q, seg_com_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    sel_digit;
    logic [7:0]    glyph;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        logic [6:0] s;
        unique case (v)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h6F;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    always_comb begin
        ctrl_d       = ctrl_q;
        digit_d      = digit_q;
        pres_d       = pres_q;
        t_d          = t_q;
        idx_d        = idx_q;
        shadow_d     = shadow_q;
        bright_d     = bright_q;
        hex_d        = hex_q;
        frame_done_d = 1'b0;
        state_d      = state_q;
        seg_com_d    = 6'h3F;
        seg_data_d   = 8'h00;
        sel_digit    = digit_q[0];
        glyph        = 8'h00;

        if (WR_EN) begin
            if (WR_ADDR == 3'd6) begin
                ctrl_d = WR_DATA[5:0];
            end
            for (int i = 0; i < 6; i++) begin
                if (WR_ADDR == 3'(i)) digit_d[i] = WR_DATA;
            end
        end

        if (!ctrl_d[4]) begin
            pres_d = '0;
            t_d    = '0;
            idx_d  = '0;
        end else if (!ctrl_q[4]) begin
            // Enabling starts a fresh slot of digit 0 with the new settings
            pres_d   = '0;
            t_d      = '0;
            idx_d    = '0;
            shadow_d = digit_q[0];
            bright_d = ctrl_d[3:0];
            hex_d    = ctrl_d[5];
        end else if (pres_q == PW'(DIV - 1)) begin
            pres_d = '0;
            t_d    = t_q + 4'd1;
            if (t_q == 4'd15) begin
                idx_d        = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                frame_done_d = (idx_q == 3'd5);
                for (int i = 0; i < 6; i++) begin
                    if (idx_d == 3'(i)) sel_digit = digit_q[i];
                end
                shadow_d = sel_digit;
                bright_d = ctrl_q[3:0];
                hex_d    = ctrl_q[5];
            end
        end else begin
            pres_d = pres_q + PW'(1);
        end

        if (!ctrl_d[4])            state_d = IDLE;
        else if (t_d == 4'd0)      state_d = GUARD;
        else if (t_d <= bright_d)  state_d = ON;
        else                       state_d = OFF;

        glyph = hex_d ? {shadow_d[7], hex7(shadow_d[3:0])} : shadow_d;
        if (state_d == ON) begin
            seg_com_d  = ~(6'b1 << idx_d);
            seg_data_d = glyph;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRESET) begin
            state_q      <= GUARD;
            ctrl_q       <= 6'h1F;
            for (int i = 0; i < 6; i++) digit_q[i] <= 8'h00;
            pres_q       <= '0;
            t_q          <= '0;
            idx_q        <= '0;
            shadow_q     <= 8'h00;
            bright_q     <= 4'hF;
            hex_q        <= 1'b0;
            seg_data_q   <= 8'h00;
            seg_com_q    <= 6'h3F;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ctrl_q       <= ctrl_d;
            digit_q      <= digit_d;
            pres_q       <= pres_d;
            t_q          <= t_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            bright_q     <= bright_d;
            hex_q        <= hex_d;
            seg_data_q   <= seg_data_d;
            seg_com_q    <= seg_com_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign SEG_DATA   = seg_data_q;
    assign SEG_COM    = seg_com_q;
    assign SCAN_IDX   = idx_q;
    assign FRAME_DONE = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl at DIV=2 (slot 32 cycles, frame 192).
module tb_seg_scan_ctrl;

    logic       CLK;
    logic       nRESET;
    logic       WR_EN;
    logic [2:0] WR_ADDR;
    logic [7:0] WR_DATA;
    logic [7:0] SEG_DATA;
    logic [5:0] SEG_COM;
    logic [2:0] SCAN_IDX;
    logic       FRAME_DONE;

    int vectors = 0;
    int miscompares = 0;

    seg_scan_ctrl #(.DIV(2)) dut (
        .CLK       (CLK),
        .nRESET    (nRESET),
        .WR_EN     (WR_EN),
        .WR_ADDR   (WR_ADDR),
        .WR_DATA   (WR_DATA),
        .SEG_DATA  (SEG_DATA),
        .SEG_COM   (SEG_COM),
        .SCAN_IDX  (SCAN_IDX),
        .FRAME_DONE(FRAME_DONE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic adv(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        WR_EN   = 1'b1;
        WR_ADDR = a;
        WR_DATA = d;
        adv(1);
        WR_EN   = 1'b0;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] com,
                           input logic [7:0] data);
        chk({tag, "_com"}, {2'b00, SEG_COM}, {2'b00, com});
        chk({tag, "_data"}, SEG_DATA, data);
    endtask

    initial begin
        nRESET  = 1'b0;
        WR_EN   = 1'b0;
        WR_ADDR = 3'd0;
        WR_DATA = 8'h00;
        adv(3);
        nRESET = 1'b1;
        // c=0: just after the reset edge
        chk_out("rst", 6'h3F, 8'h00);
        chk("rst_idx", {5'b0, SCAN_IDX}, 8'd0);
        chk("rst_fd", {7'b0, FRAME_DONE}, 8'd0);
        adv(2);
        chk("c2_data", SEG_DATA, 8'h00);
        adv(29);
        chk("c31_idx", {5'b0, SCAN_IDX}, 8'd0);
        adv(1);
        chk("c32_idx", {5'b0, SCAN_IDX}, 8'd1);
        chk("c32_com", {2'b0, SEG_COM}, 8'h3F);
        adv(159);
        chk("c191_fd", {7'b0, FRAME_DONE}, 8'd0);
        adv(1);
        chk("c192_fd", {7'b0, FRAME_DONE}, 8'd1);
        chk("c192_idx", {5'b0, SCAN_IDX}, 8'd0);
        adv(1);
        chk("c193_fd", {7'b0, FRAME_DONE}, 8'd0);

        // raw mode, digit 2 = A5
        wr(3'd2, 8'hA5);
        adv(62);
        chk("raw_guard_idx", {5'b0, SCAN_IDX}, 8'd2);
        chk_out("raw_guard", 6'h3F, 8'h00);
        adv(2);
        chk_out("raw_on_first", 6'h3B, 8'hA5);
        adv(29);
        chk_out("raw_on_last", 6'h3B, 8'hA5);
        adv(1);
        chk_out("raw_next_guard", 6'h3F, 8'h00);
        chk("raw_next_idx", {5'b0, SCAN_IDX}, 8'd3);

        // hex mode, BRIGHT=4, digit 0 = 8B
        wr(3'd6, 8'h34);
        wr(3'd0, 8'h8B);
        adv(94);
        chk("hex_fd", {7'b0, FRAME_DONE}, 8'd1);
        chk_out("hex_guard", 6'h3F, 8'h00);
        adv(2);
        chk_out("hex_on_first", 6'h3E, 8'hFC);
        adv(7);
        chk_out("hex_on_last", 6'h3E, 8'hFC);
        adv(1);
        chk_out("hex_off", 6'h3F, 8'h00);

        // mid-slot write to digit 1 must not tear
        adv(24);
        chk_out("mid_before", 6'h3D, 8'h3F);
        adv(4);
        wr(3'd1, 8'h06);
        adv(1);
        chk_out("mid_after", 6'h3D, 8'h3F);
        adv(2);
        chk_out("mid_off", 6'h3F, 8'h00);
        adv(184);
        chk_out("mid_next_frame", 6'h3D, 8'h7D);

        // disable during digit 3 ON, then re-enable
        adv(64);
        chk_out("dis_pre", 6'h37, 8'h3F);
        chk("dis_pre_idx", {5'b0, SCAN_IDX}, 8'd3);
        adv(1);
        wr(3'd6, 8'h0F);
        chk_out("dis", 6'h3F, 8'h00);
        chk("dis_idx", {5'b0, SCAN_IDX}, 8'd0);
        adv(40);
        chk_out("dis_hold", 6'h3F, 8'h00);
        chk("dis_hold_idx", {5'b0, SCAN_IDX}, 8'd0);
        wr(3'd6, 8'h1F);
        chk_out("en_guard", 6'h3F, 8'h00);
        adv(2);
        chk_out("en_on", 6'h3E, 8'h8B);

        // reset during digit 4 ON
        adv(128);
        chk_out("d4_on", 6'h2F, 8'h00);
        chk("d4_idx", {5'b0, SCAN_IDX}, 8'd4);
        nRESET = 1'b0;
        adv(1);
        nRESET = 1'b1;
        chk_out("rst2", 6'h3F, 8'h00);
        chk("rst2_idx", {5'b0, SCAN_IDX}, 8'd0);
        chk("rst2_fd", {7'b0, FRAME_DONE}, 8'd0);
        adv(2);
        chk("rst2_d0_data", SEG_DATA, 8'h00);
        wr(3'd7, 8'h00);
        adv(29);
        chk("rst2_c32_idx", {5'b0, SCAN_IDX}, 8'd1);
        adv(34);
        chk("rst2_c66_idx", {5'b0, SCAN_IDX}, 8'd2);
        chk("rst2_d2_data", SEG_DATA, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
